// File: rtl/link_pkg.sv
// Shared constants and width helpers for the link FIFO and its testbenches.
package link_pkg;

    // Defaults shared with the ring testbenches.
    localparam int unsigned DefaultWidth = 1;
    localparam int unsigned DefaultDepth = 4;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to index depth entries; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/link_fifo_if.sv
// Producer/consumer handshake bundle for link_fifo, plus its occupancy monitors.
interface link_fifo_if
    import link_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
);
    localparam int unsigned CW = count_width(DEPTH);

    logic             i_in_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] i_in_data;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [WIDTH-1:0] o_out_data;
    logic [CW-1:0]    o_count;
    logic [CW-1:0]    o_max_count;

    // FIFO side.
    modport slave (
        input  i_in_valid,
        input  i_in_data,
        input  i_out_ready,
        output o_in_ready,
        output o_out_valid,
        output o_out_data,
        output o_count,
        output o_max_count
    );

    // Producer/consumer side.
    modport master (
        output i_in_valid,
        output i_in_data,
        output i_out_ready,
        input  o_in_ready,
        input  o_out_valid,
        input  o_out_data,
        input  o_count,
        input  o_max_count
    );

endinterface

// File: rtl/link_wrap_ptr.sv
// Modulo-DEPTH pointer; wraps by explicit compare so non-power-of-two depths work.
module link_wrap_ptr
    import link_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_inc,
    output logic [ptr_width(DEPTH)-1:0] o_ptr
);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [PW-1:0] ptr_q;

    // Advance on i_inc, returning to 0 after the last entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else if (i_inc) begin
            ptr_q <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/link_fifo.sv
// Valid/ready FIFO feeding the sub_reg stage. Flags come only from the registered
// count, so no input reaches an output combinationally. DEPTH must be at least 2.
module link_fifo
    import link_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic        i_clk,
    input  logic        i_rst,
    link_fifo_if.slave  bus
);
    localparam int unsigned CW = count_width(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    max_q, max_d;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             in_ready, out_valid;
    logic             push, pop;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);

    // When full, in_ready is low, so a same-cycle pop never lets a push in.
    assign push = bus.i_in_valid & in_ready;
    assign pop  = out_valid & bus.i_out_ready;

    link_wrap_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (push),
        .o_ptr (wr_ptr)
    );

    link_wrap_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (pop),
        .o_ptr (rd_ptr)
    );

    // Next occupancy and running peak of that occupancy.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        max_d = (count_d > max_q) ? count_d : max_q;
    end

    // Occupancy and high-watermark registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
            max_q   <= '0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

    // Storage; cleared on reset so the head reads 0 until the first push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr] <= bus.i_in_data;
        end
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_out_valid = out_valid;
    assign bus.o_out_data  = mem_q[rd_ptr];
    assign bus.o_count     = count_q;
    assign bus.o_max_count = max_q;

endmodule

// File: tb/tb_link_fifo.sv
// Directed and random-backpressure bench for link_fifo at DEPTH=4 and DEPTH=3.
module tb_link_fifo;
    import link_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D4 = 4;
    localparam int unsigned D3 = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    link_fifo_if #(.WIDTH(W), .DEPTH(D4)) bus4 ();
    link_fifo_if #(.WIDTH(W), .DEPTH(D3)) bus3 ();

    link_fifo #(.WIDTH(W), .DEPTH(D4)) dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4)
    );

    link_fifo #(.WIDTH(W), .DEPTH(D3)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus3)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive4(input logic v, input logic [W-1:0] d, input logic r);
        bus4.i_in_valid  = v;
        bus4.i_in_data   = d;
        bus4.i_out_ready = r;
    endtask

    task automatic drive3(input logic v, input logic [W-1:0] d, input logic r);
        bus3.i_in_valid  = v;
        bus3.i_in_data   = d;
        bus3.i_out_ready = r;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset4(input string tag);
        check_eq({tag, "_in_ready"}, 32'(bus4.o_in_ready), 1);
        check_eq({tag, "_out_valid"}, 32'(bus4.o_out_valid), 0);
        check_eq({tag, "_out_data"}, 32'(bus4.o_out_data), 0);
        check_eq({tag, "_count"}, 32'(bus4.o_count), 0);
        check_eq({tag, "_max"}, 32'(bus4.o_max_count), 0);
    endtask

    logic [W-1:0] q[$];
    int unsigned  peak;
    logic         rv, rr;
    logic [W-1:0] rd;
    logic         mpush, mpop;

    initial begin
        rst = 1'b1;
        drive4(1'b0, '0, 1'b0);
        drive3(1'b0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check_reset4("por");
        check_eq("por3_count", 32'(bus3.o_count), 0);

        // Basic push then pop.
        drive4(1'b1, 8'h0A, 1'b0);
        tick();
        drive4(1'b0, '0, 1'b0);
        check_eq("basic_valid", 32'(bus4.o_out_valid), 1);
        check_eq("basic_data", 32'(bus4.o_out_data), 32'h0A);
        check_eq("basic_count", 32'(bus4.o_count), 1);
        drive4(1'b0, '0, 1'b1);
        tick();
        drive4(1'b0, '0, 1'b0);
        check_eq("basic_pop_count", 32'(bus4.o_count), 0);
        check_eq("basic_pop_valid", 32'(bus4.o_out_valid), 0);

        // Fill to full, stall a held word, then drain.
        for (int i = 1; i <= 4; i++) begin
            drive4(1'b1, W'(i), 1'b0);
            tick();
        end
        check_eq("full_count", 32'(bus4.o_count), 4);
        check_eq("full_in_ready", 32'(bus4.o_in_ready), 0);
        drive4(1'b1, 8'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_count", 32'(bus4.o_count), 4);
        end
        check_eq("stall_in_ready", 32'(bus4.o_in_ready), 0);
        check_eq("drain_head1", 32'(bus4.o_out_data), 1);
        drive4(1'b1, 8'd5, 1'b1);
        tick();
        check_eq("fullpop_count", 32'(bus4.o_count), 3);
        check_eq("fullpop_in_ready", 32'(bus4.o_in_ready), 1);
        drive4(1'b1, 8'd5, 1'b0);
        tick();
        drive4(1'b0, '0, 1'b0);
        check_eq("accept5_count", 32'(bus4.o_count), 4);
        check_eq("fill_max", 32'(bus4.o_max_count), 4);
        drive4(1'b0, '0, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            check_eq("drain_data", 32'(bus4.o_out_data), 32'(i));
            check_eq("drain_valid", 32'(bus4.o_out_valid), 1);
            tick();
        end
        drive4(1'b0, '0, 1'b0);
        check_eq("drain_count", 32'(bus4.o_count), 0);

        // Push and pop together at count 1.
        drive4(1'b1, 8'd7, 1'b0);
        tick();
        check_eq("sim_head7", 32'(bus4.o_out_data), 7);
        drive4(1'b1, 8'd8, 1'b1);
        tick();
        check_eq("sim_count", 32'(bus4.o_count), 1);
        check_eq("sim_head8", 32'(bus4.o_out_data), 8);
        drive4(1'b0, '0, 1'b1);
        tick();
        drive4(1'b0, '0, 1'b0);
        check_eq("sim_empty", 32'(bus4.o_count), 0);

        // DEPTH=3 wrap: ten push/pop pairs walk both pointers round three times.
        for (int i = 0; i < 10; i++) begin
            drive3(1'b1, W'(i), 1'b0);
            tick();
            check_eq("wrap_data", 32'(bus3.o_out_data), 32'(i));
            check_eq("wrap_count1", 32'(bus3.o_count), 1);
            drive3(1'b0, '0, 1'b1);
            tick();
            check_eq("wrap_count0", 32'(bus3.o_count), 0);
        end
        drive3(1'b0, '0, 1'b0);
        check_eq("wrap_max", 32'(bus3.o_max_count), 1);

        // Asynchronous reset with two words held.
        drive4(1'b1, 8'h11, 1'b0);
        tick();
        drive4(1'b1, 8'h22, 1'b0);
        tick();
        drive4(1'b0, '0, 1'b0);
        check_eq("held_count", 32'(bus4.o_count), 2);
        rst = 1'b1;
        #1;
        check_reset4("async");
        tick();
        rst = 1'b0;
        drive4(1'b1, 8'h33, 1'b0);
        tick();
        drive4(1'b0, '0, 1'b0);
        check_eq("post_rst_data", 32'(bus4.o_out_data), 32'h33);
        check_eq("post_rst_count", 32'(bus4.o_count), 1);
        check_eq("post_rst_max", 32'(bus4.o_max_count), 1);

        // Random backpressure against a queue model, from a clean reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        peak = 0;
        for (int c = 0; c < 1000; c++) begin
            check_eq("rnd_count", 32'(bus4.o_count), 32'(q.size()));
            check_eq("rnd_valid", 32'(bus4.o_out_valid), 32'(q.size() != 0));
            check_eq("rnd_in_ready", 32'(bus4.o_in_ready), 32'(q.size() != D4));
            check_eq("rnd_max", 32'(bus4.o_max_count), peak);
            if (q.size() != 0) begin
                check_eq("rnd_data", 32'(bus4.o_out_data), 32'(q[0]));
            end
            rv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rd = W'($urandom_range(0, 255));
            drive4(rv, rd, rr);
            mpush = rv && (q.size() != D4);
            mpop  = rr && (q.size() != 0);
            tick();
            if (mpop) begin
                void'(q.pop_front());
            end
            if (mpush) begin
                q.push_back(rd);
            end
            if (q.size() > peak) begin
                peak = q.size();
            end
        end
        drive4(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
